// File: rtl/ring_decoder.sv
// ring_decoder
//
// Receive-side companion to a rotate-left one-hot ring counter. Decodes each
// valid one-hot sample to its bit index. Locks onto a legal rotation stream
// after LOCK_CNT consecutive good samples. Flags illegal (non-one-hot) codes
// and sequence breaks while locked.
//
// Optional feature: define RING_DEC_WRAP_CNT_EN to add the wrap_cnt port and
// its revolution counter.
//
// Parameters:
//   WIDTH     ring length in bits (2..16)
//   LOCK_CNT  consecutive good samples needed to lock, counting the first (2..15)
//   CNT_W     revolution counter width
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; overrides all other inputs
//   ring_in      ring-counter sample
//   ring_valid   ring_in is meaningful this cycle
//   idx          bit position of the last valid one-hot sample
//   idx_valid    idx was updated from a valid one-hot sample this cycle
//   locked       decoder is tracking a legal stream
//   err_illegal  one-cycle pulse: valid sample was not one-hot (while locked)
//   err_seq      one-cycle pulse: valid one-hot sample was not the successor (while locked)
//   wrap_cnt     full-revolution count (RING_DEC_WRAP_CNT_EN only)
//
// All outputs are registered; a sample taken at edge N shows after edge N.

module ring_decoder #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           ring_in,
    input  logic                       ring_valid,
    output logic [$clog2(WIDTH)-1:0]   idx,
    output logic                       idx_valid,
    output logic                       locked,
    output logic                       err_illegal,
`ifdef RING_DEC_WRAP_CNT_EN
    output logic                       err_seq,
    output logic [CNT_W-1:0]           wrap_cnt
`else
    output logic                       err_seq
`endif
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [0:0] {StHunt, StTrack} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [3:0]         good_cnt_q, good_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               idx_valid_q, idx_valid_d;
    logic               err_illegal_q, err_illegal_d;
    logic               err_seq_q, err_seq_d;

    logic               is_onehot;
    logic               is_succ;
    logic [IDX_W-1:0]   enc;
    logic               wrap_inc;

    // Power-of-two test: exactly one bit set.
    assign is_onehot = (ring_in != '0) && ((ring_in & (ring_in - ONE)) == '0);

    // prev of all-zero (after reset) rotates to zero, so nothing matches it.
    assign is_succ = (ring_in == {prev_q[WIDTH-2:0], prev_q[WIDTH-1]});

    always_comb begin
        enc = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (ring_in[i]) begin
                enc = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        good_cnt_d    = good_cnt_q;
        idx_d         = idx_q;
        idx_valid_d   = 1'b0;
        err_illegal_d = 1'b0;
        err_seq_d     = 1'b0;
        wrap_inc      = 1'b0;

        if (ring_valid) begin
            if (is_onehot) begin
                idx_d       = enc;
                idx_valid_d = 1'b1;
                prev_d      = ring_in;
            end

            unique case (state_q)
                StHunt: begin
                    if (!is_onehot) begin
                        good_cnt_d = 4'd0;
                    end else if (is_succ && (good_cnt_q != 4'd0)) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_d == 4'(LOCK_CNT)) begin
                            state_d = StTrack;
                        end
                    end else begin
                        good_cnt_d = 4'd1;
                    end
                end
                StTrack: begin
                    if (!is_onehot) begin
                        err_illegal_d = 1'b1;
                        state_d       = StHunt;
                        good_cnt_d    = 4'd0;
                    end else if (!is_succ) begin
                        // The offending sample starts a fresh run of one.
                        err_seq_d  = 1'b1;
                        state_d    = StHunt;
                        good_cnt_d = 4'd1;
                    end else begin
                        wrap_inc = prev_q[WIDTH-1];
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StHunt;
            prev_q        <= '0;
            good_cnt_q    <= 4'd0;
            idx_q         <= '0;
            idx_valid_q   <= 1'b0;
            err_illegal_q <= 1'b0;
            err_seq_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            good_cnt_q    <= good_cnt_d;
            idx_q         <= idx_d;
            idx_valid_q   <= idx_valid_d;
            err_illegal_q <= err_illegal_d;
            err_seq_q     <= err_seq_d;
        end
    end

    assign idx         = idx_q;
    assign idx_valid   = idx_valid_q;
    assign locked      = (state_q == StTrack);
    assign err_illegal = err_illegal_q;
    assign err_seq     = err_seq_q;

`ifdef RING_DEC_WRAP_CNT_EN
    logic [CNT_W-1:0] wrap_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_cnt_q <= '0;
        end else if (wrap_inc) begin
            wrap_cnt_q <= wrap_cnt_q + CNT_W'(1);
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap_inc;
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// Testbench for ring_decoder: directed scenarios followed by randomized
// stimulus, all checked cycle by cycle against a behavioural index-based model.

module tb_ring_decoder;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned LOCK_CNT = 2;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned IDX_W    = $clog2(WIDTH);

    logic                 clk;
    logic                 rst;
    logic [WIDTH-1:0]     ring_in;
    logic                 ring_valid;
    logic [IDX_W-1:0]     idx;
    logic                 idx_valid;
    logic                 locked;
    logic                 err_illegal;
    logic                 err_seq;
`ifdef RING_DEC_WRAP_CNT_EN
    logic [CNT_W-1:0]     wrap_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    ring_decoder #(
        .WIDTH    (WIDTH),
        .LOCK_CNT (LOCK_CNT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ring_in     (ring_in),
        .ring_valid  (ring_valid),
        .idx         (idx),
        .idx_valid   (idx_valid),
        .locked      (locked),
        .err_illegal (err_illegal),
`ifdef RING_DEC_WRAP_CNT_EN
        .err_seq     (err_seq),
        .wrap_cnt    (wrap_cnt)
`else
        .err_seq     (err_seq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: positions as integers, -1 = no previous sample.
    int m_prev;
    int m_good;
    bit m_locked;
    int m_idx;
    bit m_iv;
    bit m_ill;
    bit m_seq;
    int m_wrap;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [WIDTH-1:0] s);
        int k;
        bit succ;
        m_iv  = 0;
        m_ill = 0;
        m_seq = 0;
        if (r) begin
            m_prev = -1; m_good = 0; m_locked = 0; m_idx = 0; m_wrap = 0;
            return;
        end
        if (!v) return;
        if ($countones(s) != 1) begin
            if (m_locked) m_ill = 1;
            m_locked = 0;
            m_good   = 0;
            return;
        end
        k = 0;
        for (int i = 0; i < int'(WIDTH); i++) if (s[i]) k = i;
        succ = (m_prev >= 0) && (k == (m_prev + 1) % int'(WIDTH));
        if (m_locked) begin
            if (succ) begin
                if (m_prev == int'(WIDTH) - 1) m_wrap = (m_wrap + 1) % (1 << CNT_W);
            end else begin
                m_seq = 1; m_locked = 0; m_good = 1;
            end
        end else if (succ && m_good >= 1) begin
            m_good++;
            if (m_good == int'(LOCK_CNT)) m_locked = 1;
        end else begin
            m_good = 1;
        end
        m_idx  = k;
        m_iv   = 1;
        m_prev = k;
    endtask

    // Drive one cycle, advance the model, compare every output.
    task automatic apply(input bit r, input bit v, input logic [WIDTH-1:0] s);
        rst        = r;
        ring_valid = v;
        ring_in    = s;
        @(posedge clk);
        #1;
        model_step(r, v, s);
        check_eq("idx", int'(idx), m_idx);
        check_eq("idx_valid", int'(idx_valid), int'(m_iv));
        check_eq("locked", int'(locked), int'(m_locked));
        check_eq("err_illegal", int'(err_illegal), int'(m_ill));
        check_eq("err_seq", int'(err_seq), int'(m_seq));
        check_eq("err_exclusive", int'(err_illegal & err_seq), 0);
`ifdef RING_DEC_WRAP_CNT_EN
        check_eq("wrap_cnt", int'(wrap_cnt), m_wrap);
`endif
    endtask

    function automatic logic [WIDTH-1:0] oh(input int k);
        logic [WIDTH-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    initial begin
        int last;
        int sel;
        logic [WIDTH-1:0] rnd;

        m_prev = -1; m_good = 0; m_locked = 0; m_idx = 0; m_wrap = 0;
        rst = 1'b1; ring_valid = 1'b0; ring_in = '0;

        // Reset state, with a valid sample present that must be ignored.
        apply(1, 1, 4'b0100);
        check_eq("rst_idx", int'(idx), 0);
        check_eq("rst_idx_valid", int'(idx_valid), 0);
        check_eq("rst_locked", int'(locked), 0);
        check_eq("rst_errs", int'({err_illegal, err_seq}), 0);

        // Scenario 1: clean rotation, lock after 2nd sample, wrap after 5th.
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, oh(i % 4));
            check_eq("s1_idx", int'(idx), i % 4);
            check_eq("s1_locked", int'(locked), (i >= 1) ? 1 : 0);
        end
`ifdef RING_DEC_WRAP_CNT_EN
        check_eq("s1_wrap", int'(wrap_cnt), 1);
`endif

        // Scenario 2: locked at 0010, then an illegal code.
        apply(0, 1, 4'b0010);
        check_eq("s2_locked_pre", int'(locked), 1);
        apply(0, 1, 4'b0110);
        check_eq("s2_err_illegal", int'(err_illegal), 1);
        check_eq("s2_idx_hold", int'(idx), 1);
        check_eq("s2_unlocked", int'(locked), 0);
        apply(0, 0, 4'b0000);
        check_eq("s2_pulse_end", int'(err_illegal), 0);

        // Scenario 3: locked at 0010, then a skip to 1000, then relock.
        apply(0, 1, 4'b0001);
        apply(0, 1, 4'b0010);
        check_eq("s3_locked_pre", int'(locked), 1);
        apply(0, 1, 4'b1000);
        check_eq("s3_err_seq", int'(err_seq), 1);
        check_eq("s3_idx", int'(idx), 3);
        check_eq("s3_unlocked", int'(locked), 0);
        apply(0, 1, 4'b0001);
        apply(0, 1, 4'b0010);
        check_eq("s3_relocked", int'(locked), 1);

        // Scenario 4: repeated sample while locked, then zero in hunt.
        apply(0, 1, 4'b0100);
        apply(0, 1, 4'b0100);
        check_eq("s4_err_seq", int'(err_seq), 1);
        check_eq("s4_unlocked", int'(locked), 0);
        apply(0, 1, 4'b0000);
        check_eq("s4_zero_no_err", int'(err_illegal), 0);
        check_eq("s4_zero_unlocked", int'(locked), 0);

        // Scenario 5: valid gap between two good samples.
        apply(0, 1, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 4'b1111);
            check_eq("s5_gap_iv", int'(idx_valid), 0);
        end
        apply(0, 1, 4'b0010);
        check_eq("s5_locked", int'(locked), 1);

        // Scenario 6: reach wrap_cnt=3, then reset alongside a valid sample.
        apply(1, 0, 4'b0000);
        for (int i = 0; i < 13; i++) apply(0, 1, oh(i % 4));
`ifdef RING_DEC_WRAP_CNT_EN
        check_eq("s6_wrap3", int'(wrap_cnt), 3);
`endif
        apply(1, 1, 4'b0100);
        check_eq("s6_rst_outs", int'({idx, idx_valid, locked, err_illegal, err_seq}), 0);
`ifdef RING_DEC_WRAP_CNT_EN
        check_eq("s6_rst_wrap", int'(wrap_cnt), 0);
`endif

        // Randomized stimulus biased toward legal rotation.
        last = 0;
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 99));
            rnd = WIDTH'($urandom);
            if (sel < 60) begin
                last = (last + 1) % int'(WIDTH);
                apply(0, 1, oh(last));
            end else if (sel < 68) begin
                apply(0, 1, oh(last));
            end else if (sel < 76) begin
                last = int'($urandom_range(0, WIDTH - 1));
                apply(0, 1, oh(last));
            end else if (sel < 84) begin
                apply(0, 1, rnd);
            end else if (sel < 87) begin
                apply(0, 1, '0);
            end else if (sel < 99) begin
                apply(0, 0, rnd);
            end else begin
                apply(1, ($urandom_range(0, 1) == 1), rnd);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
